// File: rtl/write_buffer_pkg.sv
// Shared types and widths for the processor-side write buffer.
package write_buffer_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        GAP   = 2'b10
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_if.sv
// Processor- and memory-side signals of the write buffer; slave is the buffer itself.
interface write_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    import write_buffer_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              proc_wen;
    logic              proc_ren;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_stall;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (
        output proc_wen, proc_ren, proc_addr, proc_wdata, mem_ready,
        input  proc_stall, fwd_hit, fwd_data, mem_wen, mem_addr, mem_wdata, empty, count
    );

    modport slave (
        input  proc_wen, proc_ren, proc_addr, proc_wdata, mem_ready,
        output proc_stall, fwd_hit, fwd_data, mem_wen, mem_addr, mem_wdata, empty, count
    );

endinterface

// File: rtl/write_buffer_fifo.sv
// wb_fifo: circular entry storage with per-slot valid bits, exposed for forwarding.
module wb_fifo
    import write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  wb_entry_t                  push_entry_i,
    input  logic                       pop_i,
    input  logic                       ovw_i,
    input  logic [DATA_W-1:0]          ovw_data_i,
    output wb_entry_t                  head_o,
    output wb_entry_t                  tail_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output wb_entry_t [DEPTH-1:0]      entries_o,
    output logic [DEPTH-1:0]           valid_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      tail_idx;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;
    assign tail_idx  = wr_ptr_q - 1'b1;
    assign head_o    = mem_q[rd_ptr_q];
    assign tail_o    = mem_q[tail_idx];
    assign count_o   = count_q;
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign rd_ptr_o  = rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
        if (ovw_i) begin
            mem_q[tail_idx].data <= ovw_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Store buffer: drains stores to memory in order with a one-cycle gap between writes,
// forwards buffered data to loads. Define WB_COALESCE_EN to merge repeat stores into the youngest entry.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    write_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_state_e             state_q;
    wb_state_e             state_d;
    wb_entry_t             last_q;
    wb_entry_t             head;
    wb_entry_t             tail;
    wb_entry_t             push_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  fifo_empty;
    logic                  coalesce;
    logic                  accept;
    logic                  pop;
    logic                  mem_wen;
    logic                  fwd_hit;
    logic [DATA_W-1:0]     fwd_data;
    logic [PTR_W-1:0]      idx;

`ifdef WB_COALESCE_EN
    // The head being presented in DRAIN must stay stable, so it is never merged into.
    assign coalesce = bus.proc_wen & ~fifo_empty & (tail.addr == bus.proc_addr)
                    & ~((state_q == DRAIN) & (count == CNT_W'(1)));
`else
    assign coalesce = 1'b0;
`endif

    assign accept          = bus.proc_wen & ~full & ~coalesce;
    assign pop             = (state_q == DRAIN) & bus.mem_ready;
    assign push_entry.addr = bus.proc_addr;
    assign push_entry.data = bus.proc_wdata;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (accept),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .ovw_i        (coalesce),
        .ovw_data_i   (bus.proc_wdata),
        .head_o       (head),
        .tail_o       (tail),
        .full_o       (full),
        .empty_o      (fifo_empty),
        .count_o      (count),
        .entries_o    (entries),
        .valid_o      (valid),
        .rd_ptr_o     (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_wen = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = DRAIN;
            end
            DRAIN: begin
                mem_wen = 1'b1;
                if (bus.mem_ready) state_d = GAP;
            end
            GAP: begin
                state_d = fifo_empty ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // The bus shows the live head while draining and replays the last head otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= '0;
        end else if (state_q == DRAIN) begin
            last_q <= head;
        end
    end

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (bus.proc_ren) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PTR_W'(k);
                if (valid[idx] && (entries[idx].addr == bus.proc_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = entries[idx].data;
                end
            end
        end
    end

    assign bus.proc_stall = bus.proc_wen & full & ~coalesce;
    assign bus.fwd_hit    = fwd_hit;
    assign bus.fwd_data   = fwd_data;
    assign bus.mem_wen    = mem_wen;
    assign bus.mem_addr   = (state_q == DRAIN) ? head.addr : last_q.addr;
    assign bus.mem_wdata  = (state_q == DRAIN) ? head.data : last_q.data;
    assign bus.empty      = fifo_empty;
    assign bus.count      = count;

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: queue-based reference model, directed scenarios then random traffic.
module tb_write_buffer;
    import write_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    write_buffer_if #(.DEPTH(DEPTH)) bus ();

    write_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int        vectors    = 0;
    int        miscompares = 0;
    wb_entry_t wq[$];
    bit        prev_hs    = 1'b0;
    wb_entry_t last_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One processor/memory cycle: drive, check combinational outputs against the model, then update it.
    task automatic cycle(input logic wen, input logic ren, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic ready);
        bit              coal;
        bit              full;
        bit              exp_hit;
        logic [DATA_W-1:0] exp_data;
        wb_entry_t       e;
        @(negedge clk);
        bus.proc_wen   = wen;
        bus.proc_ren   = ren;
        bus.proc_addr  = addr;
        bus.proc_wdata = data;
        bus.mem_ready  = ready;
        #1;
        coal = 1'b0;
`ifdef WB_COALESCE_EN
        coal = wen && (wq.size() > 0) && (wq[wq.size()-1].addr == addr)
             && !(bus.mem_wen && (wq.size() == 1));
`endif
        full     = (wq.size() == DEPTH);
        exp_hit  = 1'b0;
        exp_data = '0;
        if (ren) begin
            foreach (wq[i]) begin
                if (wq[i].addr == addr) begin
                    exp_hit  = 1'b1;
                    exp_data = wq[i].data;
                end
            end
        end
        check("proc_stall", 64'(bus.proc_stall), 64'(wen && full && !coal));
        check("fwd_hit",    64'(bus.fwd_hit),    64'(exp_hit));
        check("fwd_data",   64'(bus.fwd_data),   64'(exp_data));
        check("count",      64'(bus.count),      64'(wq.size()));
        check("empty",      64'(bus.empty),      64'(wq.size() == 0));
        if (coal) begin
            wq[wq.size()-1].data = data;
        end else if (wen && !full) begin
            e.addr = addr;
            e.data = data;
            wq.push_back(e);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 80; n++) begin
            if (wq.size() == 0 && !bus.mem_wen) break;
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
        end
        check("drained", 64'(wq.size()), 64'd0);
    endtask

    // Monitor: every presented write must be the model's oldest entry, followed by a one-cycle gap.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    check("gap_wen",   64'(bus.mem_wen),   64'd0);
                    check("gap_addr",  64'(bus.mem_addr),  64'(last_wr.addr));
                    check("gap_wdata", 64'(bus.mem_wdata), 64'(last_wr.data));
                end
                prev_hs = 1'b0;
                if (bus.mem_wen) begin
                    if (wq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL stale_write: got addr %0h data %0h required no write at %0t",
                                 bus.mem_addr, bus.mem_wdata, $time);
                    end else begin
                        check("mem_addr",  64'(bus.mem_addr),  64'(wq[0].addr));
                        check("mem_wdata", 64'(bus.mem_wdata), 64'(wq[0].data));
                        if (bus.mem_ready) begin
                            last_wr = wq.pop_front();
                            prev_hs = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.proc_wen   = 1'b0;
        bus.proc_ren   = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_ready  = 1'b0;
        rst            = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count",  64'(bus.count),     64'd0);
        check("rst_empty",  64'(bus.empty),     64'd1);
        check("rst_wen",    64'(bus.mem_wen),   64'd0);
        check("rst_addr",   64'(bus.mem_addr),  64'd0);
        check("rst_wdata",  64'(bus.mem_wdata), 64'd0);
        rst = 1'b1;

        // Single store: two-cycle latency to mem_wen, one-cycle pulse, then empty.
        cycle(1'b1, 1'b0, 30'd0, 32'd60, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("lat_idle_wen", 64'(bus.mem_wen), 64'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("lat_wen",   64'(bus.mem_wen),   64'd1);
        check("lat_wdata", 64'(bus.mem_wdata), 64'd60);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("pulse_end", 64'(bus.mem_wen), 64'd0);
        check("one_empty", 64'(bus.empty),   64'd1);

        // Five stores into a blocked memory: fifth stalls, then four ordered writes.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 30'(16 + i), 32'(100 + i), 1'b0);
            if (i == 4) check("fifth_stall", 64'(bus.proc_stall), 64'd1);
        end
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("full_count", 64'(bus.count), 64'd4);
        drain();

        // Full buffer, pop and store in the same cycle: store stalls, retried next cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 30'(32 + i), 32'(200 + i), 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b0, 30'd40, 32'd77, 1'b1);
        check("pop_push_stall", 64'(bus.proc_stall), 64'd1);
        cycle(1'b1, 1'b0, 30'd40, 32'd77, 1'b0);
        check("pop_push_count", 64'(bus.count),      64'd3);
        check("retry_accept",   64'(bus.proc_stall), 64'd0);
        drain();

        // Forwarding returns the youngest match.
        cycle(1'b1, 1'b0, 30'd8, 32'd1, 1'b0);
        cycle(1'b1, 1'b0, 30'd8, 32'd2, 1'b0);
        cycle(1'b0, 1'b1, 30'd8, '0, 1'b0);
        check("fwd8_hit",  64'(bus.fwd_hit),  64'd1);
        check("fwd8_data", 64'(bus.fwd_data), 64'd2);
        cycle(1'b0, 1'b1, 30'd9, '0, 1'b0);
        check("fwd9_hit",  64'(bus.fwd_hit),  64'd0);
        drain();

`ifdef WB_COALESCE_EN
        cycle(1'b1, 1'b0, 30'd3, 32'd9, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b0, 30'd5, 32'd10, 1'b0);
        cycle(1'b1, 1'b0, 30'd5, 32'd11, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("coal_count", 64'(bus.count), 64'd2);
        drain();
`endif

        // Reset mid-drain discards pending entries and drops mem_wen immediately.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 30'(48 + i), 32'(300 + i), 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("pre_rst_wen", 64'(bus.mem_wen), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_wen",   64'(bus.mem_wen), 64'd0);
        check("mid_rst_count", 64'(bus.count),   64'd0);
        wq.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1);

        // Randomized traffic over a small address range to exercise forwarding and wrap.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  30'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 9) < 6));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
